bcd_to_binary_seq: RTL and testbench

- Sequential multi-digit packed-BCD to unsigned binary converter. It performs the reverse of the team's binary-to-BCD block and is used where decimal-entered or decimal-displayed values must return to binary arithmetic.
- Evaluates one digit per clock using Horner accumulation (acc = acc*10 + digit), most significant digit first.
- Valid/ready handshake on both the input and output sides.
- Flags any nibble greater than 9 as an error instead of converting it.

---
 rtl/bcd_to_binary_seq.sv | 139 +++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter: Horner accumulation,
// one digit per clock (most significant first), valid/ready on both sides.
module bcd_to_binary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MUL_W = BIN_W + 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               bad_nibble;
  logic [3:0]         top_nib;
  logic [BIN_W-1:0]   acc_next;

  // A word is rejected as a whole if any of its digits is out of range.
  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_nibble = 1'b1;
    end
  end

  // Multiply-add is evaluated at BIN_W+4 bits, then truncated back to BIN_W.
  assign top_nib  = sr_q[SR_W-1 -: 4];
  assign acc_next = BIN_W'({4'b0, acc_q} * MUL_W'(10) + MUL_W'(top_nib));

  // NOTE: every _d is defaulted to its _q first so no path through the case
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid && in_ready_q) begin
          sr_d       = bcd_in;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          if (bad_nibble) begin
            bin_d       = '0;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_CONV;
          end
        end
      end

      S_CONV: begin
        acc_d = acc_next;
        sr_d  = sr_q << 4;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bin_d       = acc_next;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: default 4-digit instance plus
// 6-digit and 1-digit instances for the width boundaries.
module tb_bcd_to_binary_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [15:0] bcd_in    = '0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [13:0] bin_out;
  logic        err;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [23:0] bcd6      = '0;
  logic        in_valid6 = 1'b0;
  logic        in_ready6;
  logic [19:0] bin6;
  logic        err6;
  logic        out_valid6;
  logic        out_ready6 = 1'b0;

  logic [3:0]  bcd1      = '0;
  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [3:0]  bin1;
  logic        err1;
  logic        out_valid1;
  logic        out_ready1 = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq u_dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .in_valid(in_valid),
    .in_ready(in_ready), .bin_out(bin_out), .err(err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  bcd_to_binary_seq #(.DIGITS(6), .BIN_W(20)) u_dut6 (
    .clk(clk), .rst(rst), .bcd_in(bcd6), .in_valid(in_valid6),
    .in_ready(in_ready6), .bin_out(bin6), .err(err6),
    .out_valid(out_valid6), .out_ready(out_ready6)
  );

  bcd_to_binary_seq #(.DIGITS(1), .BIN_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .bcd_in(bcd1), .in_valid(in_valid1),
    .in_ready(in_ready1), .bin_out(bin1), .err(err1),
    .out_valid(out_valid1), .out_ready(out_ready1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word until it is accepted (bounded), then drop in_valid.
  task automatic send(input logic [15:0] v);
    logic seen;
    bcd_in   = v;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      seen = in_ready;
      tick();
      if (seen) break;
    end
    in_valid = 1'b0;
  endtask

  // Edges after accept until out_valid is seen; -1 if it never appears.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({in_ready, out_valid, err, bin_out} !== 17'h0) begin
      bad++;
      $display("FAIL reset_values: got ir=%0b ov=%0b err=%0b bin=%0h want all 0",
               in_ready, out_valid, err, bin_out);
    end
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: got %0b want 0", in_ready);
    end
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_release: got ir=%0b ov=%0b want ir=1 ov=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat;
    send(16'h1234);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_ready_drop: got %0b want 0", in_ready);
    end
    wait_out(lat);
    total++;
    if (lat !== 4 || bin_out !== 14'h04D2 || err !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_1234: got lat=%0d bin=%0h err=%0b ir=%0b want lat=4 bin=4d2 err=0 ir=0",
               lat, bin_out, err, in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_handshake: got ov=%0b ir=%0b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ov, exp_ir;
    int   outs = 0;
    out_ready = 1'b1;
    bcd_in    = 16'h9999;
    in_valid  = 1'b1;
    tick();                       // edge 0: 9999 accepted
    bcd_in = 16'h0000;            // in_valid stays high for the next word
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_ov = (k == 4) || (k == 10);
      exp_ir = (k == 5) || (k == 11);
      if (k == 11) in_valid = 1'b0;
      total++;
      if (out_valid !== exp_ov || in_ready !== exp_ir) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got ov=%0b ir=%0b want ov=%0b ir=%0b",
                 k, out_valid, in_ready, exp_ov, exp_ir);
      end
      if (out_valid) begin
        outs++;
        total++;
        if ((k == 4 && bin_out !== 14'h270F) || (k == 10 && bin_out !== 14'h0000) || err !== 1'b0) begin
          bad++;
          $display("FAIL b2b_value%0d: got bin=%0h err=%0b want %0h err=0",
                   k, bin_out, err, (k == 4) ? 14'h270F : 14'h0000);
        end
      end
    end
    out_ready = 1'b0;
    total++;
    if (outs !== 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d outputs want 2", outs);
    end
  endtask

  task automatic test_error();
    int lat;
    send(16'h12A4);
    wait_out(lat);
    total++;
    if (lat !== 0 || err !== 1'b1 || bin_out !== 14'h0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL err_12A4: got lat=%0d err=%0b bin=%0h ir=%0b want lat=0 err=1 bin=0 ir=0",
               lat, err, bin_out, in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send(16'h0042);
    wait_out(lat);
    total++;
    if (lat !== 4 || err !== 1'b0 || bin_out !== 14'd42) begin
      bad++;
      $display("FAIL err_clears_0042: got lat=%0d err=%0b bin=%0d want lat=4 err=0 bin=42",
               lat, err, bin_out);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int lat;
    send(16'h0507);
    wait_out(lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL stall_latency: got %0d want 4", lat);
    end
    bcd_in = 16'h9999;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      tick();
      total++;
      if (out_valid !== 1'b1 || bin_out !== 14'd507 || err !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d: got ov=%0b bin=%0d err=%0b ir=%0b want ov=1 bin=507 err=0 ir=0",
                 k, out_valid, bin_out, err, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: got ov=%0b ir=%0b want ov=0 ir=1", out_valid, in_ready);
    end
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_no_stored_word: got ov=%0b ir=%0b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    send(16'h8765);
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, err, bin_out} !== 17'h0) begin
      bad++;
      $display("FAIL async_reset: got ir=%0b ov=%0b err=%0b bin=%0h want all 0",
               in_ready, out_valid, err, bin_out);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_recover: got ir=%0b ov=%0b want ir=1 ov=0", in_ready, out_valid);
    end
    send(16'h0001);
    wait_out(lat);
    total++;
    if (lat !== 4 || bin_out !== 14'd1 || err !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_0001: got lat=%0d bin=%0d err=%0b want lat=4 bin=1 err=0",
               lat, bin_out, err);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_wide();
    int lat = -1;
    bcd6      = 24'h999999;
    in_valid6 = 1'b1;
    tick();
    in_valid6 = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      if (out_valid6) begin
        lat = i;
        break;
      end
      tick();
    end
    total++;
    if (lat !== 6 || bin6 !== 20'hF423F || err6 !== 1'b0) begin
      bad++;
      $display("FAIL wide_999999: got lat=%0d bin=%0h err=%0b want lat=6 bin=f423f err=0",
               lat, bin6, err6);
    end
    out_ready6 = 1'b1;
    tick();
    out_ready6 = 1'b0;
  endtask

  task automatic test_one_digit();
    int lat = -1;
    bcd1      = 4'h7;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      if (out_valid1) begin
        lat = i;
        break;
      end
      tick();
    end
    total++;
    if (lat !== 1 || bin1 !== 4'd7 || err1 !== 1'b0) begin
      bad++;
      $display("FAIL one_digit_7: got lat=%0d bin=%0d err=%0b want lat=1 bin=7 err=0",
               lat, bin1, err1);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    bcd1      = 4'hB;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    total++;
    if (out_valid1 !== 1'b1 || err1 !== 1'b1 || bin1 !== 4'd0) begin
      bad++;
      $display("FAIL one_digit_B: got ov=%0b err=%0b bin=%0d want ov=1 err=1 bin=0",
               out_valid1, err1, bin1);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_error();
    test_stall();
    test_reset_mid();
    test_wide();
    test_one_digit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
